neuron_mac: RTL and testbench



---
 rtl/neuron_mac_if.sv | 30 +++
 rtl/neuron_mac.sv | 105 ++++++++++
 tb/tb_neuron_mac.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/neuron_mac_if.sv
// neuron_mac_if: handshake and data bundle between a neuron_mac and its driver.
//   master : issues start/bias, streams (x_in, w_in) pairs, consumes zed
//   slave  : the neuron_mac itself
// Signals:
//   start/bias           command to begin one accumulation, with its signed bias
//   in_valid/in_ready    per-pair handshake for x_in (unsigned) and w_in (signed)
//   out_valid/out_ready  result handshake for zed (offset-binary, 128 = zero)
//   busy                 high whenever the neuron is not idle
interface neuron_mac_if;
   logic               start;
   logic signed [15:0] bias;
   logic               in_valid;
   logic               in_ready;
   logic [7:0]         x_in;
   logic signed [7:0]  w_in;
   logic               out_valid;
   logic               out_ready;
   logic [7:0]         zed;
   logic               busy;

   modport master (
      output start, bias, in_valid, x_in, w_in, out_ready,
      input  in_ready, out_valid, zed, busy
   );

   modport slave (
      input  start, bias, in_valid, x_in, w_in, out_ready,
      output in_ready, out_valid, zed, busy
   );
endinterface

// File: rtl/neuron_mac.sv
// neuron_mac: sequential multiply-accumulate neuron feeding an 8-bit sigmoid LUT.
// Accumulates N_INPUTS products x*w on top of a signed bias, arithmetic-shifts
// right by SHIFT, saturates to [-128,127] and presents the result offset by 128.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  neuron_mac_if.slave (start/bias, input stream, zed result, busy)
// ACC_W must be at least 18 + clog2(N_INPUTS) so the accumulator never wraps.
module neuron_mac #(
   parameter int unsigned N_INPUTS = 784,
   parameter int unsigned ACC_W    = 32,
   parameter int unsigned SHIFT    = 8
) (
   input  logic         clk,
   input  logic         rst,
   neuron_mac_if.slave  bus
);

   localparam int unsigned PROD_W = 17;
   localparam int unsigned BIAS_W = 16;
   localparam int unsigned CNT_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(N_INPUTS - 1);
   localparam logic signed [ACC_W-1:0] S_MAX    = ACC_W'(127);
   localparam logic signed [ACC_W-1:0] S_MIN    = ACC_W'(-128);

   typedef enum logic [1:0] {IDLE, ACC, SCALE, DONE} state_t;

   state_t                   state;
   logic signed [ACC_W-1:0]  acc;
   logic [CNT_W-1:0]         cnt;

   logic signed [PROD_W-1:0] prod_c;
   logic signed [ACC_W-1:0]  prod_ext_c;
   logic signed [ACC_W-1:0]  bias_ext_c;
   logic signed [ACC_W-1:0]  scaled_c;
   logic [7:0]               zed_c;

   // Activation is unsigned: a zero MSB makes the 9-bit operand non-negative.
   assign prod_c     = $signed({1'b0, bus.x_in}) * bus.w_in;
   assign prod_ext_c = $signed({{(ACC_W-PROD_W){prod_c[PROD_W-1]}}, prod_c});
   assign bias_ext_c = $signed({{(ACC_W-BIAS_W){bus.bias[BIAS_W-1]}}, bus.bias});

   // Floor-divide by 2^SHIFT, then saturate and convert to offset binary.
   assign scaled_c = acc >>> SHIFT;

   always_comb begin
      zed_c = {~scaled_c[7], scaled_c[6:0]};
      if (scaled_c > S_MAX) begin
         zed_c = 8'd255;
      end else if (scaled_c < S_MIN) begin
         zed_c = 8'd0;
      end
   end

   // Control FSM with registered handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         acc           <= '0;
         cnt           <= '0;
         bus.zed       <= 8'd128;
         bus.out_valid <= 1'b0;
         bus.in_ready  <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  acc          <= bias_ext_c;
                  cnt          <= '0;
                  bus.in_ready <= 1'b1;
                  bus.busy     <= 1'b1;
                  state        <= ACC;
               end
            end
            ACC: begin
               if (bus.in_valid && bus.in_ready) begin
                  acc <= acc + prod_ext_c;
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == CNT_LAST) begin
                     bus.in_ready <= 1'b0;
                     state        <= SCALE;
                  end
               end
            end
            SCALE: begin
               bus.zed       <= zed_c;
               bus.out_valid <= 1'b1;
               state         <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.busy      <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: directed and randomized checks of neuron_mac with N_INPUTS=4,
// SHIFT=4 against an arithmetic reference model of the neuron.
module tb_neuron_mac;

   localparam int unsigned N     = 4;
   localparam int unsigned SHIFT = 4;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   logic [7:0]        cur_x [N];
   logic signed [7:0] cur_w [N];

   neuron_mac_if bus ();

   neuron_mac #(.N_INPUTS(N), .ACC_W(32), .SHIFT(SHIFT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: bias + sum(x*w), floor-divided by 2^SHIFT, clamped, offset by 128.
   function automatic logic [7:0] model(input logic signed [15:0] b);
      longint sum;
      longint s;
      sum = longint'(b);
      for (int i = 0; i < N; i++) sum += longint'(cur_x[i]) * longint'(cur_w[i]);
      s = sum >>> SHIFT;
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      return 8'(s + 128);
   endfunction

   task automatic set_xw(input logic [7:0] x, input logic signed [7:0] w);
      for (int i = 0; i < N; i++) begin
         cur_x[i] = x;
         cur_w[i] = w;
      end
   endtask

   // One full transaction; gap stall cycles before each beat, hold cycles of
   // out_ready low in DONE, optional start pulse while accumulating.
   task automatic run_op(input string nm, input logic signed [15:0] b, input int gap,
                         input int hold, input bit pulse, input logic [7:0] exp_zed);
      bus.bias  = b;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.bias  = 16'($urandom);
      check({nm, "/in_ready"}, 32'(bus.in_ready), 32'd1);
      check({nm, "/busy"}, 32'(bus.busy), 32'd1);
      for (int i = 0; i < N; i++) begin
         for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            bus.x_in     = 8'($urandom);
            bus.w_in     = 8'($urandom);
            if (pulse && i == 1 && g == 0) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            check({nm, "/stall_rdy"}, 32'(bus.in_ready), 32'd1);
            check({nm, "/stall_ov"}, 32'(bus.out_valid), 32'd0);
         end
         bus.in_valid = 1'b1;
         bus.x_in     = cur_x[i];
         bus.w_in     = cur_w[i];
         tick();
         bus.in_valid = 1'b0;
      end
      check({nm, "/scale_ov"}, 32'(bus.out_valid), 32'd0);
      check({nm, "/scale_rdy"}, 32'(bus.in_ready), 32'd0);
      tick();
      check({nm, "/out_valid"}, 32'(bus.out_valid), 32'd1);
      check({nm, "/zed"}, 32'(bus.zed), 32'(exp_zed));
      for (int h = 0; h < hold; h++) begin
         tick();
         check({nm, "/hold_ov"}, 32'(bus.out_valid), 32'd1);
         check({nm, "/hold_zed"}, 32'(bus.zed), 32'(exp_zed));
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check({nm, "/post_ov"}, 32'(bus.out_valid), 32'd0);
      check({nm, "/post_busy"}, 32'(bus.busy), 32'd0);
      check({nm, "/post_zed"}, 32'(bus.zed), 32'(exp_zed));
   endtask

   initial begin
      logic signed [15:0] rb;
      errors        = 0;
      checks        = 0;
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.bias      = '0;
      bus.in_valid  = 1'b0;
      bus.x_in      = '0;
      bus.w_in      = '0;
      bus.out_ready = 1'b0;
      #3;
      check("rst/zed", 32'(bus.zed), 32'd128);
      check("rst/out_valid", 32'(bus.out_valid), 32'd0);
      check("rst/in_ready", 32'(bus.in_ready), 32'd0);
      check("rst/busy", 32'(bus.busy), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      set_xw(8'd16, 8'sd1);
      run_op("basic", 16'sd0, 0, 0, 1'b0, 8'd132);
      run_op("stall", 16'sd0, 3, 5, 1'b1, 8'd132);

      set_xw(8'd255, 8'sd127);
      run_op("sat_pos", 16'sd0, 0, 1, 1'b0, 8'd255);
      set_xw(8'd255, 8'sh80);
      run_op("sat_neg", 16'sd0, 0, 0, 1'b0, 8'd0);
      set_xw(8'd0, 8'sd77);
      run_op("floor", -16'sd1, 0, 0, 1'b0, 8'd127);
      set_xw(8'd0, -8'sd5);
      run_op("b2b", 16'sd32, 0, 0, 1'b0, 8'd130);

      // Abort mid-accumulation with an asynchronous reset.
      set_xw(8'd100, 8'sd50);
      bus.bias  = 16'sd1000;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.in_valid = 1'b1;
         bus.x_in     = cur_x[i];
         bus.w_in     = cur_w[i];
         tick();
      end
      bus.in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("abort/zed", 32'(bus.zed), 32'd128);
      check("abort/out_valid", 32'(bus.out_valid), 32'd0);
      check("abort/in_ready", 32'(bus.in_ready), 32'd0);
      check("abort/busy", 32'(bus.busy), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      tick();
      check("abort/idle_rdy", 32'(bus.in_ready), 32'd0);
      check("abort/idle_busy", 32'(bus.busy), 32'd0);
      set_xw(8'd16, 8'sd1);
      run_op("fresh", 16'sd0, 0, 0, 1'b0, 8'd132);

      for (int t = 0; t < 25; t++) begin
         for (int i = 0; i < N; i++) begin
            cur_x[i] = 8'($urandom);
            cur_w[i] = 8'($urandom);
         end
         rb = 16'($urandom);
         if (t % 3 == 0) rb = 16'($signed(8'($urandom)));
         run_op("rand", rb, int'($urandom_range(2, 0)), int'($urandom_range(3, 0)),
                1'($urandom), model(rb));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
